// File: rtl/exe_bypass_queue_pkg.sv
// Shared types and constants for the execute-stage bypass queue.
// Holds the default-width entry layout and the hard-wired zero register index.
package exe_pkg;

  localparam int EXE_DATA_W = 32;
  localparam int EXE_REG_W  = 6;
  localparam int EXE_SIDE_W = 136;

  // Register index that never produces a forwarding match
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [EXE_DATA_W-1:0] res;
    logic [EXE_DATA_W-1:0] mdata;
    logic [EXE_REG_W-1:0]  dest;
    logic                  wb;
    logic                  load;
    logic [EXE_SIDE_W-1:0] side;
  } exe_entry_t;

endpackage

// File: rtl/exe_bypass_queue_if.sv
// Producer/consumer handshake and bypass lookup bundle for exe_bypass_queue.
// Its parameters must match those of the queue instance it is bound to.
interface exe_bypass_queue_if #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 6,
  parameter int SIDE_W = 136,
  parameter int NRD    = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              push;
  logic [DATA_W-1:0] din_res;
  logic [DATA_W-1:0] din_mdata;
  logic [REG_W-1:0]  din_dest;
  logic              din_wb;
  logic              din_load;
  logic [SIDE_W-1:0] din_side;
  logic              pop;
  logic              flush;

  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] dout_res;
  logic [DATA_W-1:0] dout_mdata;
  logic [REG_W-1:0]  dout_dest;
  logic              dout_wb;
  logic              dout_load;
  logic [SIDE_W-1:0] dout_side;

  logic [NRD*REG_W-1:0]  radr;
  logic [NRD-1:0]        fwd_hit;
  logic [NRD*DATA_W-1:0] fwd_data;
  logic [NRD-1:0]        fwd_block;

  modport master (
    output push, din_res, din_mdata, din_dest, din_wb, din_load, din_side,
    output pop, flush, radr,
    input  full, empty, count,
    input  dout_res, dout_mdata, dout_dest, dout_wb, dout_load, dout_side,
    input  fwd_hit, fwd_data, fwd_block
  );

  modport slave (
    input  push, din_res, din_mdata, din_dest, din_wb, din_load, din_side,
    input  pop, flush, radr,
    output full, empty, count,
    output dout_res, dout_mdata, dout_dest, dout_wb, dout_load, dout_side,
    output fwd_hit, fwd_data, fwd_block
  );

endinterface

// File: rtl/exe_bypass_queue_match.sv
// Youngest-entry bypass match for one lookup port (module exeq_match).
// EXE_BYPASS_QUEUE_FWD_EN selects data forwarding; otherwise a match only stalls.
module exeq_match
  import exe_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int REG_W  = 6,
  parameter int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0]        vld,
  input  logic [DEPTH-1:0]        wb,
  input  logic [DEPTH-1:0]        load,
  input  logic [DEPTH*REG_W-1:0]  dest,
  input  logic [DEPTH*DATA_W-1:0] res,
  input  logic [PW-1:0]           wr_ptr,
  input  logic [REG_W-1:0]        radr,
  output logic                    hit,
  output logic [DATA_W-1:0]       data,
  output logic                    block
);

  logic              found;
  logic              win_load;
  logic [DATA_W-1:0] win_res;
  logic [PW-1:0]     sel;
  int                idx;

  // Walk slots from the most recently written one backwards; first match is youngest.
  always_comb begin
    found    = 1'b0;
    win_load = 1'b0;
    win_res  = '0;
    sel      = '0;
    idx      = 0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = int'(wr_ptr) + DEPTH - 1 - k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      sel = PW'(idx);
      if (!found && vld[sel] && wb[sel] &&
          dest[sel*REG_W +: REG_W] == radr && radr != REG_W'(REG_ZERO)) begin
        found    = 1'b1;
        win_load = load[sel];
        win_res  = res[sel*DATA_W +: DATA_W];
      end
    end
  end

`ifdef EXE_BYPASS_QUEUE_FWD_EN
  assign hit   = found && !win_load;
  assign data  = (found && !win_load) ? win_res : '0;
  assign block = found && win_load;
`else
  logic unused_fwd;
  assign unused_fwd = ^{win_load, win_res};
  assign hit   = 1'b0;
  assign data  = '0;
  assign block = found;
`endif

endmodule

// File: rtl/exe_bypass_queue.sv
// Execute-to-memory result queue with per-port youngest-match bypass lookup.
// Forwarding behaviour is selected by EXE_BYPASS_QUEUE_FWD_EN (see exeq_match).
module exe_bypass_queue
  import exe_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = EXE_DATA_W,
  parameter int REG_W  = EXE_REG_W,
  parameter int SIDE_W = EXE_SIDE_W,
  parameter int NRD    = 2
) (
  input logic clk,
  input logic reset,
  exe_bypass_queue_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Same field layout as exe_entry_t, sized by this instance's parameters
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] mdata;
    logic [REG_W-1:0]  dest;
    logic              wb;
    logic              load;
    logic [SIDE_W-1:0] side;
  } slot_t;

  slot_t            slot_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  slot_t din;
  slot_t head;
  logic  push_ok;
  logic  pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign din = '{res: bus.din_res, mdata: bus.din_mdata, dest: bus.din_dest,
                 wb: bus.din_wb, load: bus.din_load, side: bus.din_side};

  assign bus.full  = (count_q == CW'(DEPTH));
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;

  // A pop on a full queue frees the slot the concurrent push lands in.
  assign pop_ok  = bus.pop && !bus.empty && !bus.flush;
  assign push_ok = bus.push && (!bus.full || bus.pop) && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (pop_ok) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= next_ptr(rd_ptr_q);
      end
      if (push_ok) begin
        vld_q[wr_ptr_q]  <= 1'b1;
        slot_q[wr_ptr_q] <= din;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
      end
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  assign head = bus.empty ? '0 : slot_q[rd_ptr_q];

  assign bus.dout_res   = head.res;
  assign bus.dout_mdata = head.mdata;
  assign bus.dout_dest  = head.dest;
  assign bus.dout_wb    = head.wb;
  assign bus.dout_load  = head.load;
  assign bus.dout_side  = head.side;

  logic [DEPTH-1:0]        wb_vec;
  logic [DEPTH-1:0]        load_vec;
  logic [DEPTH*REG_W-1:0]  dest_vec;
  logic [DEPTH*DATA_W-1:0] res_vec;

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign wb_vec[i]                    = slot_q[i].wb;
    assign load_vec[i]                  = slot_q[i].load;
    assign dest_vec[i*REG_W +: REG_W]   = slot_q[i].dest;
    assign res_vec[i*DATA_W +: DATA_W]  = slot_q[i].res;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    exeq_match #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .REG_W  (REG_W),
      .PW     (PW)
    ) u_match (
      .vld    (vld_q),
      .wb     (wb_vec),
      .load   (load_vec),
      .dest   (dest_vec),
      .res    (res_vec),
      .wr_ptr (wr_ptr_q),
      .radr   (bus.radr[p*REG_W +: REG_W]),
      .hit    (bus.fwd_hit[p]),
      .data   (bus.fwd_data[p*DATA_W +: DATA_W]),
      .block  (bus.fwd_block[p])
    );
  end

endmodule

// File: tb/tb_exe_bypass_queue.sv
// Scoreboard bench for exe_bypass_queue: DEPTH=4 (two lookup ports) and DEPTH=3 wrap instance.
// Forward expectations follow EXE_BYPASS_QUEUE_FWD_EN as defined for the build.
module tb_exe_bypass_queue;

`ifdef EXE_BYPASS_QUEUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]  res;
    logic [31:0]  mdata;
    logic [5:0]   dest;
    logic         wb;
    logic         load;
    logic [135:0] side;
  } ent_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   mc4   = 0;
  int   mc3   = 0;
  int   n3    = 0;
  ent_t exp4[$];
  ent_t exp3[$];

  exe_bypass_queue_if #(.DEPTH(4))            b4();
  exe_bypass_queue_if #(.DEPTH(3), .NRD(1))   b3();

  exe_bypass_queue #(.DEPTH(4))          u_q4 (.clk(clk), .reset(rst), .bus(b4));
  exe_bypass_queue #(.DEPTH(3), .NRD(1)) u_q3 (.clk(clk), .reset(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  function automatic ent_t mk(input logic [31:0] res, input logic [5:0] dest,
                              input logic wb, input logic load);
    ent_t e;
    e.res   = res;
    e.mdata = res ^ 32'hFFFF_0000;
    e.dest  = dest;
    e.wb    = wb;
    e.load  = load;
    e.side  = {8'h5A, 96'h0, res};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input ent_t e, input bit pu, input bit po, input bit fl);
    bit pa, pp;
    b4.push      = pu;
    b4.pop       = po;
    b4.flush     = fl;
    b4.din_res   = e.res;
    b4.din_mdata = e.mdata;
    b4.din_dest  = e.dest;
    b4.din_wb    = e.wb;
    b4.din_load  = e.load;
    b4.din_side  = e.side;
    if (fl) begin
      exp4.delete();
      mc4 = 0;
    end else begin
      pa = pu && (mc4 != 4 || po);
      pp = po && (mc4 != 0);
      if (pa) exp4.push_back(e);
      mc4 = mc4 + int'(pa) - int'(pp);
    end
    step();
    b4.push  = 1'b0;
    b4.pop   = 1'b0;
    b4.flush = 1'b0;
  endtask

  task automatic drive3(input ent_t e, input bit pu, input bit po);
    bit pa, pp;
    b3.push      = pu;
    b3.pop       = po;
    b3.din_res   = e.res;
    b3.din_mdata = e.mdata;
    b3.din_dest  = e.dest;
    b3.din_wb    = e.wb;
    b3.din_load  = e.load;
    b3.din_side  = e.side;
    pa = pu && (mc3 != 3 || po);
    pp = po && (mc3 != 0);
    if (pa) exp3.push_back(e);
    mc3 = mc3 + int'(pa) - int'(pp);
    step();
    b3.push = 1'b0;
    b3.pop  = 1'b0;
  endtask

  // Monitors: an accepted pop presents the head entry, which must match the scoreboard
  always @(negedge clk) begin
    ent_t a, w;
    if (!rst && b4.pop && !b4.empty && !b4.flush) begin
      a = '{res: b4.dout_res, mdata: b4.dout_mdata, dest: b4.dout_dest,
            wb: b4.dout_wb, load: b4.dout_load, side: b4.dout_side};
      total++;
      if (exp4.size() == 0) begin
        bad++;
        $display("FAIL q4_head: got res %0h with no expected entry", a.res);
      end else begin
        w = exp4.pop_front();
        if (a !== w) begin
          bad++;
          $display("FAIL q4_head: got res %0h dest %0h want res %0h dest %0h",
                   a.res, a.dest, w.res, w.dest);
        end
      end
    end
  end

  always @(negedge clk) begin
    ent_t a, w;
    if (!rst && b3.pop && !b3.empty && !b3.flush) begin
      a = '{res: b3.dout_res, mdata: b3.dout_mdata, dest: b3.dout_dest,
            wb: b3.dout_wb, load: b3.dout_load, side: b3.dout_side};
      total++;
      n3++;
      if (exp3.size() == 0) begin
        bad++;
        $display("FAIL q3_head: got res %0h with no expected entry", a.res);
      end else begin
        w = exp3.pop_front();
        if (a !== w) begin
          bad++;
          $display("FAIL q3_head: got res %0h want res %0h", a.res, w.res);
        end
      end
    end
  end

  initial begin
    ent_t idle;
    idle = '0;
    rst = 1'b1;
    b4.push = 1'b0; b4.pop = 1'b0; b4.flush = 1'b0; b4.radr = '0;
    b4.din_res = '0; b4.din_mdata = '0; b4.din_dest = '0;
    b4.din_wb = 1'b0; b4.din_load = 1'b0; b4.din_side = '0;
    b3.push = 1'b0; b3.pop = 1'b0; b3.flush = 1'b0; b3.radr = '0;
    b3.din_res = '0; b3.din_mdata = '0; b3.din_dest = '0;
    b3.din_wb = 1'b0; b3.din_load = 1'b0; b3.din_side = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_empty", 64'(b4.empty), 64'd1);
    chk("rst_full", 64'(b4.full), 64'd0);
    chk("rst_count", 64'(b4.count), 64'd0);
    chk("rst_dout_res", 64'(b4.dout_res), 64'd0);
    chk("rst_fwd_hit", 64'(b4.fwd_hit), 64'd0);
    chk("rst_fwd_block", 64'(b4.fwd_block), 64'd0);

    // Fill: A/B share dest 5, C is a load to 7, D does not write back
    drive4(mk(32'h11, 6'd5, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    chk("push1_count", 64'(b4.count), 64'd1);
    chk("push1_dout_res", 64'(b4.dout_res), 64'h11);
    chk("push1_dout_dest", 64'(b4.dout_dest), 64'd5);
    drive4(mk(32'h22, 6'd5, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    b4.radr = {6'd0, 6'd5};
    #1;
    chk("fwd0_hit_young", 64'(b4.fwd_hit[0]), 64'(FWD));
    chk("fwd0_data_young", 64'(b4.fwd_data[31:0]), FWD ? 64'h22 : 64'h0);
    chk("fwd0_block", 64'(b4.fwd_block[0]), 64'(!FWD));
    chk("fwd1_zero_hit", 64'(b4.fwd_hit[1]), 64'd0);
    chk("fwd1_zero_block", 64'(b4.fwd_block[1]), 64'd0);
    drive4(mk(32'h33, 6'd7, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0);
    b4.radr = {6'd7, 6'd5};
    #1;
    chk("fwd1_load_hit", 64'(b4.fwd_hit[1]), 64'd0);
    chk("fwd1_load_block", 64'(b4.fwd_block[1]), 64'd1);
    drive4(mk(32'h44, 6'd9, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    b4.radr = {6'd9, 6'd5};
    #1;
    chk("fwd1_nowb_block", 64'(b4.fwd_block[1]), 64'd0);
    chk("fwd1_nowb_hit", 64'(b4.fwd_hit[1]), 64'd0);
    chk("full_count", 64'(b4.count), 64'd4);
    chk("full_flag", 64'(b4.full), 64'd1);

    drive4(mk(32'hEE, 6'd5, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    chk("drop_count", 64'(b4.count), 64'd4);
    chk("drop_full", 64'(b4.full), 64'd1);

    drive4(mk(32'h55, 6'd3, 1'b1, 1'b0), 1'b1, 1'b1, 1'b0);
    chk("pp_full_count", 64'(b4.count), 64'd4);
    chk("pp_fwd0_data", 64'(b4.fwd_data[31:0]), FWD ? 64'h22 : 64'h0);
    chk("pp_fwd0_block", 64'(b4.fwd_block[0]), 64'(!FWD));

    repeat (4) drive4(idle, 1'b0, 1'b1, 1'b0);
    chk("drain_count", 64'(b4.count), 64'd0);
    chk("drain_empty", 64'(b4.empty), 64'd1);
    drive4(idle, 1'b0, 1'b1, 1'b0);
    chk("pop_empty_count", 64'(b4.count), 64'd0);
    chk("pop_empty_flag", 64'(b4.empty), 64'd1);

    // Flush with three queued and a concurrent push
    drive4(mk(32'h66, 6'd5, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    drive4(mk(32'h77, 6'd6, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    drive4(mk(32'h88, 6'd8, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(b4.count), 64'd3);
    b4.radr = {6'd0, 6'd5};
    drive4(mk(32'h99, 6'd5, 1'b1, 1'b0), 1'b1, 1'b0, 1'b1);
    chk("flush_empty", 64'(b4.empty), 64'd1);
    chk("flush_count", 64'(b4.count), 64'd0);
    chk("flush_dout_res", 64'(b4.dout_res), 64'd0);
    chk("flush_dout_side", 64'(|b4.dout_side), 64'd0);
    chk("flush_fwd_block", 64'(b4.fwd_block[0]), 64'd0);
    drive4(mk(32'hAA, 6'd4, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    drive4(idle, 1'b0, 1'b1, 1'b0);
    chk("post_flush_count", 64'(b4.count), 64'd0);

    // Reset mid-operation overrides a push
    drive4(mk(32'hB1, 6'd2, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    drive4(mk(32'hB2, 6'd2, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    drive4(mk(32'hB3, 6'd2, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    exp4.delete();
    mc4 = 0;
    chk("midrst_empty", 64'(b4.empty), 64'd1);
    chk("midrst_count", 64'(b4.count), 64'd0);

    // DEPTH=3 wrap: one primer then ten push/pop pairs
    drive3(mk(32'h1000, 6'd1, 1'b1, 1'b0), 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++)
      drive3(mk(32'h1000 + 32'(i), 6'd1, 1'b1, 1'b0), 1'b1, 1'b1);
    chk("q3_pair_count", 64'(b3.count), 64'd1);
    drive3(idle, 1'b0, 1'b1);
    chk("q3_end_empty", 64'(b3.empty), 64'd1);
    chk("q3_outputs", 64'(n3), 64'd11);
    chk("q4_sb_left", 64'(exp4.size()), 64'd0);
    chk("q3_sb_left", 64'(exp3.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
